// File: rtl/piton_vortex_dcr_pkg.sv
// piton_vortex_dcr_pkg: shared register map, STATUS layout and FSM encoding for the DCR control front end
package piton_vortex_dcr_pkg;
    localparam logic [11:0] DCR_ADDR_OFF = 12'h000;
    localparam logic [11:0] DCR_DATA_OFF = 12'h008;
    localparam logic [11:0] DCR_PAIR_OFF = 12'h010;
    localparam logic [11:0] STATUS_OFF   = 12'h018;
    localparam logic [11:0] ERR_CLR_OFF  = 12'h020;
    localparam int STAT_FULL_BIT = 0;
    localparam int STAT_BUSY_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;
    localparam int STAT_CNT_LSB  = 16;
    localparam int PUSH_CNT_W    = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, PUSH = 2'd1, RESP = 2'd2} dcr_state_e;
endpackage

// File: rtl/piton_dcr_stall_timer.sv
// piton_dcr_stall_timer: counts enabled cycles; ports clk, rst_n, clear, enable, timeout -> expired
module piton_dcr_stall_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] timeout,
    output logic        expired
);
    logic [31:0] cnt;
    // fires in the enabled cycle whose count increment reaches timeout; timeout 0 never fires
    assign expired = enable && (timeout != '0) && (cnt == timeout - 32'd1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= clear ? '0 : enable ? cnt + 32'd1 : cnt;
    end
endmodule

// File: rtl/piton_dcr_core_ctrl.sv
// piton_dcr_core_ctrl: MMIO req/resp front end turning 64-bit register writes into Vortex DCR buffer pushes; exposes STATUS, push count and sticky error
module piton_dcr_core_ctrl
    import piton_vortex_dcr_pkg::*;
#(
    parameter int VX_DCR_ADDR_WIDTH = 8,
    parameter int VX_DCR_DATA_WIDTH = 32,
    parameter int STALL_TIMEOUT     = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [11:0]                  req_addr,
    input  logic [63:0]                  req_wdata,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [63:0]                  resp_rdata,
    output logic                         resp_err,
    output logic                         buffer_wr_valid,
    output logic [VX_DCR_ADDR_WIDTH-1:0] buffer_wr_addr,
    output logic [VX_DCR_DATA_WIDTH-1:0] buffer_wr_data,
    input  logic                         buffer_full,
    input  logic                         vx_busy
);
    localparam int AW = VX_DCR_ADDR_WIDTH;
    dcr_state_e state_q, state_d;
    logic ready_q, err_q, resp_err_q, expired, acc, mapped, is_push, timed_out, err_set, err_clr;
    logic is_addr, is_data, is_pair, is_stat, is_clr;
    logic [11:0] off;
    logic [AW-1:0] staged_q;
    logic [PUSH_CNT_W-1:0] push_cnt_q;
    logic [63:0] status, rd_data, rdata_q;
    logic unused;
    assign unused = ^{req_addr[2:0], req_wdata[63:32+AW]};
    assign off = {req_addr[11:3], 3'b000};
    assign is_addr = off == DCR_ADDR_OFF;
    assign is_data = off == DCR_DATA_OFF;
    assign is_pair = off == DCR_PAIR_OFF;
    assign is_stat = off == STATUS_OFF;
    assign is_clr = off == ERR_CLR_OFF;
    assign mapped = is_addr | is_data | is_pair | is_stat | is_clr;
    // req_ready is only high in IDLE, so acceptance implies the FSM is idle
    assign acc = req_valid && ready_q;
    assign is_push = req_we && (is_data || is_pair);
    assign req_ready = ready_q;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err = resp_err_q;
    assign buffer_wr_valid = (state_q == PUSH) && !buffer_full;
    assign timed_out = (state_q == PUSH) && expired;
    assign err_set = (acc && !mapped) || timed_out;
    assign err_clr = acc && req_we && is_clr;
    always_comb begin
        status = '0;
        status[STAT_FULL_BIT] = buffer_full;
        status[STAT_BUSY_BIT] = vx_busy;
        status[STAT_ERR_BIT] = err_q;
        status[STAT_CNT_LSB +: PUSH_CNT_W] = push_cnt_q;
        rd_data = req_we ? '0 : is_addr ? 64'(staged_q) : is_stat ? status : '0;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = acc ? (is_push ? PUSH : RESP) : IDLE;
            PUSH: state_d = (!buffer_full || expired) ? RESP : PUSH;
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    piton_dcr_stall_timer u_stall (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != PUSH),
        .enable  ((state_q == PUSH) && buffer_full),
        .timeout (32'(STALL_TIMEOUT)),
        .expired (expired)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            err_q <= 1'b0;
            resp_err_q <= 1'b0;
            rdata_q <= '0;
            staged_q <= '0;
            push_cnt_q <= '0;
            buffer_wr_addr <= '0;
            buffer_wr_data <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= state_d == IDLE;
            // a new error event wins over a simultaneous clear
            err_q <= err_set || (err_q && !err_clr);
            if (acc) begin
                rdata_q <= rd_data;
                resp_err_q <= !mapped;
                if (req_we && is_addr) staged_q <= req_wdata[AW-1:0];
                if (is_push) begin
                    buffer_wr_addr <= is_pair ? req_wdata[32 +: AW] : staged_q;
                    buffer_wr_data <= req_wdata[VX_DCR_DATA_WIDTH-1:0];
                end
            end
            if (buffer_wr_valid) push_cnt_q <= push_cnt_q + 1'b1;
            if (timed_out) resp_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_piton_dcr_core_ctrl.sv
// tb_piton_dcr_core_ctrl: directed self-checking bench for piton_dcr_core_ctrl
module tb_piton_dcr_core_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1, buffer_full = 1'b0, vx_busy = 1'b0;
    logic [11:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic req_ready, resp_valid, resp_err, buffer_wr_valid;
    logic [63:0] resp_rdata;
    logic [7:0] buffer_wr_addr;
    logic [31:0] buffer_wr_data;
    int checks = 0, passes = 0, pushes = 0, snap;
    logic [63:0] rd;
    logic er;
    always #5 clk = ~clk;
    piton_dcr_core_ctrl #(.STALL_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .buffer_wr_valid(buffer_wr_valid),
        .buffer_wr_addr(buffer_wr_addr), .buffer_wr_data(buffer_wr_data), .buffer_full(buffer_full),
        .vx_busy(vx_busy)
    );
    always @(posedge clk) if (buffer_wr_valid) pushes <= pushes + 1;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic send(input logic we, input logic [11:0] a, input logic [63:0] d);
        int n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("req_ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
    endtask
    task automatic recv(output logic [63:0] r, output logic e);
        int n = 0;
        while (!resp_valid && n < 100) begin @(negedge clk); n++; end
        check("resp_valid", resp_valid, 1);
        r = resp_rdata; e = resp_err;
        @(posedge clk); @(negedge clk);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check("rst_outs", {req_ready, resp_valid, resp_err, buffer_wr_valid}, 4'b0);
        check("rst_data", {resp_rdata, buffer_wr_addr, buffer_wr_data}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);
        send(1, 12'h000, 64'h5);
        check("nonpush_latency", resp_valid, 1);
        recv(rd, er);
        check("wr_addr_err", er, 0);
        check("wr_rdata", rd, 0);
        send(1, 12'h008, 64'hDEADBEEF);
        check("push_valid", buffer_wr_valid, 1);
        check("push_addr", buffer_wr_addr, 8'h05);
        check("push_data", buffer_wr_data, 32'hDEADBEEF);
        recv(rd, er);
        check("push_err", er, 0);
        check("push_count1", pushes, 1);
        vx_busy = 1'b1;
        send(0, 12'h01C, 64'h0);
        recv(rd, er);
        check("status1", rd, 64'h10002);
        send(1, 12'h010, 64'h0000_0012_0000_0001);
        check("pair_addr", buffer_wr_addr, 8'h12);
        check("pair_data", buffer_wr_data, 32'h1);
        recv(rd, er);
        check("pair_err", er, 0);
        send(0, 12'h000, 64'h0);
        recv(rd, er);
        check("staged_kept", rd, 64'h5);
        buffer_full = 1'b1;
        snap = pushes;
        send(1, 12'h008, 64'hCAFE);
        for (int i = 0; i < 10; i++) begin
            check("stall_no_push", buffer_wr_valid, 0);
            @(negedge clk);
        end
        buffer_full = 1'b0;
        #1;
        check("stall_push", buffer_wr_valid, 1);
        check("stall_data", {buffer_wr_addr, buffer_wr_data}, {8'h05, 32'hCAFE});
        recv(rd, er);
        check("stall_err", er, 0);
        check("stall_one_push", pushes, snap + 1);
        buffer_full = 1'b1;
        snap = pushes;
        send(1, 12'h008, 64'h77);
        begin
            int n = 0;
            while (!resp_valid && n < 100) begin n++; @(negedge clk); end
            check("timeout_cycles", n, 16);
        end
        recv(rd, er);
        check("timeout_err", er, 1);
        check("timeout_no_push", pushes, snap);
        buffer_full = 1'b0;
        send(0, 12'h018, 64'h0);
        recv(rd, er);
        check("status_err", rd, 64'h30006);
        send(1, 12'h020, 64'h0);
        recv(rd, er);
        check("errclr_err", er, 0);
        send(0, 12'h018, 64'h0);
        recv(rd, er);
        check("status_clr", rd, 64'h30002);
        send(1, 12'h018, 64'hFFFF);
        recv(rd, er);
        check("status_wr_ign", er, 0);
        resp_ready = 1'b0;
        send(0, 12'h040, 64'h0);
        for (int i = 0; i < 5; i++) begin
            check("hold_resp", {resp_valid, resp_err, req_ready, resp_rdata}, {3'b110, 64'h0});
            @(negedge clk);
        end
        resp_ready = 1'b1;
        recv(rd, er);
        check("unmapped_err", er, 1);
        check("unmapped_rd", rd, 0);
        buffer_full = 1'b1;
        snap = pushes;
        send(1, 12'h010, 64'h0000_0033_0000_00AA);
        check("pre_rst_addr", buffer_wr_addr, 8'h33);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {req_ready, resp_valid, resp_err, buffer_wr_valid}, 4'b0);
        check("mid_rst_data", {resp_rdata, buffer_wr_addr, buffer_wr_data}, '0);
        buffer_full = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, 12'h018, 64'h0);
        recv(rd, er);
        check("rst_no_push", pushes, snap);
        check("status_after_rst", rd, 64'h2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
